dec_unbinder_scan: RTL and testbench
====================================

Name: dec_unbinder_scan

Overview:
- Decode-side counterpart of the encoder binder stage.
- Takes one bound (shifted) hypervector, undoes the fixed cyclic shift, and scans the level hypervector bank one entry per cycle.
- Each entry gets an overlap score; the block reports the best-matching level index and its score.
- Sits after associative-memory readout, feeding per-feature level recovery to the decoding controller.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- SHIFT, 0, cyclic shift applied by the matching encoder binder; range 0..HV_DIM-1.
- NUM_LEVELS, 10, number of level hypervectors scanned.
- IDX_W, $clog2(NUM_LEVELS), width of level_idx.
- SCORE_W, $clog2(HV_DIM+1), width of best_score.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  reset; asynchronous, active-high (asserted when 1).
- start_decoding  input  1  request; sampled only in IDLE.
- bound_hv  input  HV_DIM  bound hypervector; sampled on the accepted start.
- level_hv  input  HV_DIM x [0:NUM_LEVELS-1]  level bank; must stay stable while busy.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse; results valid.
- level_idx  output  IDX_W  best-matching level index.
- best_score  output  SCORE_W  popcount overlap of the best match.

Behaviour:
- Binding convention: encoder rotates left by SHIFT, so bit i moves to (i+SHIFT) mod HV_DIM. This block rotates right by SHIFT, so unbound[i] = bound_hv[(i+SHIFT) mod HV_DIM]. SHIFT=0 is identity.
- Reset (async assert, any state): state=IDLE; busy=0, done=0, level_idx=0, best_score=0; unbound register, scan counter and running best all cleared.
- States:
  - IDLE: if start_decoding=1 at an edge, latch the right-rotated bound_hv into the unbound register, clear running best (idx 0, score 0), set k=0, go to SCAN.
  - SCAN: each cycle compute s = popcount(unbound & level_hv[k]). If s > running score (strictly), update running best to (k, s). After k=NUM_LEVELS-1, go to DONE; otherwise k++.
  - DONE: one cycle. done=1; level_idx/best_score show the final best. Next edge returns to IDLE.
- Ties: the lowest index wins because updates require strictly greater.
- All-zero overlaps: level_idx=0, best_score=0.
- Timing, with start sampled at edge t:
  - busy=1 during cycles t+1 .. t+NUM_LEVELS, which are the SCAN cycles.
  - done=1 during cycle t+NUM_LEVELS+1; busy=0 in that cycle.
  - Back-to-back starts give one result per NUM_LEVELS+2 cycles.
- Outputs:
  - level_idx and best_score are registered and update only on entry to DONE.
  - They hold their value through IDLE until the next DONE.
  - They are not cleared on start.
- start_decoding while in SCAN or DONE is ignored; there is no queuing.
- bound_hv changes after acceptance have no effect.
- level_hv changes during SCAN give undefined scores but must not corrupt FSM sequencing.
- Reset mid-SCAN: immediate IDLE, outputs zero, no done pulse.
- Popcount: full HV_DIM-bit AND + popcount in one cycle. The sum is SCORE_W wide, and a score of HV_DIM must not overflow.

Test Plan:
- Basic decode (HV_DIM=16, SHIFT=3, NUM_LEVELS=4): level_hv = {0x0000, 0x0030, 0x00F0, 0x0F00}; bound_hv=0x0780 (rotl3 of 0x00F0); pulse start at cycle 0 -> busy cycles 1-4, done at cycle 5, level_idx=2, best_score=4.
- Wrap-around rotation: same setup, level_hv[1]=0x8001, others 0; bound_hv=0x000C -> level_idx=1, best_score=2.
- Tie and zero cases:
  - level_hv[0]=level_hv[3]=0x000F, bound_hv=0x0078 -> level_idx=0, best_score=4.
  - All levels 0 -> level_idx=0, best_score=0.
- Ignored start plus full-match width: start re-asserted on cycles 2 and 5 of a scan -> only one done pulse, and the next scan begins only from a start sampled in IDLE.
  - SHIFT=0, bound_hv=level_hv[3]=0xFFFF -> best_score=16 with no overflow.
- Reset mid-operation: assert nrst=1 asynchronously during cycle 2 of SCAN -> busy, done, level_idx and best_score all 0 immediately; no done pulse. A new start after release produces a correct result after 5 cycles.

Source files
------------

// File: rtl/dec_unbinder_scan.sv
// Decode-side unbinder: undoes the encoder's cyclic shift on a bound
// hypervector, then scans the level bank one entry per cycle and reports
// the best-overlapping level index and its popcount score.
//
// Ports:
//   clk            rising-edge clock
//   nrst           asynchronous reset, active-high (asserted when 1)
//   start_decoding request, sampled only while idle
//   bound_hv       bound hypervector, captured on the accepted start
//   level_hv       level hypervector bank, held stable while busy
//   busy           high during the scan cycles
//   done           one-cycle pulse, results valid
//   level_idx      best-matching level index (held until next done)
//   best_score     popcount overlap of the best match (held until next done)
module dec_unbinder_scan #(
    parameter int HV_DIM     = 1024,
    parameter int SHIFT      = 0,
    parameter int NUM_LEVELS = 10,
    parameter int IDX_W      = $clog2(NUM_LEVELS),
    parameter int SCORE_W    = $clog2(HV_DIM + 1)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start_decoding,
    input  logic [HV_DIM-1:0]   bound_hv,
    input  logic [HV_DIM-1:0]   level_hv [0:NUM_LEVELS-1],
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    level_idx,
    output logic [SCORE_W-1:0]  best_score
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [HV_DIM-1:0]   unbound;
    logic [HV_DIM-1:0]   rotated;
    logic [HV_DIM-1:0]   overlap_bits;
    logic [IDX_W-1:0]    k;
    logic [IDX_W-1:0]    run_idx;
    logic [SCORE_W-1:0]  run_score;
    logic [SCORE_W-1:0]  score;
    logic                better;
    logic                last;

    // Right rotation by SHIFT: inverse of the encoder's left rotation.
    for (genvar g = 0; g < HV_DIM; g++) begin : g_rot
        assign rotated[g] = bound_hv[(g + SHIFT) % HV_DIM];
    end

    assign overlap_bits = unbound & level_hv[k];

    // Sum is SCORE_W wide so a full HV_DIM match cannot overflow.
    always_comb begin
        score = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            score = score + SCORE_W'(overlap_bits[i]);
        end
    end

    // Strict compare keeps the lowest index on ties.
    assign better = (score > run_score);
    assign last   = (k == IDX_W'(NUM_LEVELS - 1));

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state      <= IDLE;
            unbound    <= '0;
            k          <= '0;
            run_idx    <= '0;
            run_score  <= '0;
            level_idx  <= '0;
            best_score <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_decoding) begin
                        unbound   <= rotated;
                        run_idx   <= '0;
                        run_score <= '0;
                        k         <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (better) begin
                        run_idx   <= k;
                        run_score <= score;
                    end
                    if (last) begin
                        // Publish including this final entry's score.
                        level_idx  <= better ? k : run_idx;
                        best_score <= better ? score : run_score;
                        state      <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_dec_unbinder_scan.sv
// Directed bench for dec_unbinder_scan: HV_DIM=16, NUM_LEVELS=4,
// one instance with SHIFT=3 and one with SHIFT=0 sharing the stimulus.
module tb_dec_unbinder_scan;

    logic        clk;
    logic        nrst;
    logic        start_decoding;
    logic [15:0] bound_hv;
    logic [15:0] level_hv [0:3];
    logic        busy;
    logic        done;
    logic [1:0]  level_idx;
    logic [4:0]  best_score;
    logic        busy0;
    logic        done0;
    logic [1:0]  level_idx0;
    logic [4:0]  best_score0;

    int pass_cnt = 0;
    int total    = 0;

    dec_unbinder_scan #(
        .HV_DIM(16), .SHIFT(3), .NUM_LEVELS(4)
    ) dut (
        .clk(clk), .nrst(nrst), .start_decoding(start_decoding),
        .bound_hv(bound_hv), .level_hv(level_hv),
        .busy(busy), .done(done),
        .level_idx(level_idx), .best_score(best_score)
    );

    dec_unbinder_scan #(
        .HV_DIM(16), .SHIFT(0), .NUM_LEVELS(4)
    ) dut0 (
        .clk(clk), .nrst(nrst), .start_decoding(start_decoding),
        .bound_hv(bound_hv), .level_hv(level_hv),
        .busy(busy0), .done(done0),
        .level_idx(level_idx0), .best_score(best_score0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_levels(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        level_hv[0] = a;
        level_hv[1] = b;
        level_hv[2] = c;
        level_hv[3] = d;
    endtask

    // Drive start so it is sampled at the next rising edge (edge t).
    task automatic pulse_start(input logic [15:0] b);
        @(negedge clk);
        bound_hv       = b;
        start_decoding = 1'b1;
        @(posedge clk);
        #1;
        start_decoding = 1'b0;
    endtask

    // Cycles after edge t until done is seen at a falling edge; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        nrst           = 1'b1;
        start_decoding = 1'b0;
        bound_hv       = '0;
        set_levels(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
        else pass_cnt++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done);
        else pass_cnt++;
        total++;
        if (level_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", level_idx);
        else pass_cnt++;
        total++;
        if (best_score !== 5'd0) $display("FAIL reset_score got %0d want 0", best_score);
        else pass_cnt++;
        nrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        set_levels(16'h0000, 16'h0030, 16'h00F0, 16'h0F00);
        pulse_start(16'h0780);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if (busy !== (c <= 4))
                $display("FAIL basic_busy c%0d got %0b want %0b", c, busy, (c <= 4));
            else pass_cnt++;
            total++;
            if (done !== (c == 5))
                $display("FAIL basic_done c%0d got %0b want %0b", c, done, (c == 5));
            else pass_cnt++;
            if (c == 5) begin
                total++;
                if (level_idx !== 2'd2) $display("FAIL basic_idx got %0d want 2", level_idx);
                else pass_cnt++;
                total++;
                if (best_score !== 5'd4) $display("FAIL basic_score got %0d want 4", best_score);
                else pass_cnt++;
                total++;
                if (level_idx0 !== 2'd3 || best_score0 !== 5'd3)
                    $display("FAIL basic_shift0 got %0d/%0d want 3/3", level_idx0, best_score0);
                else pass_cnt++;
            end
        end
        total++;
        if (level_idx !== 2'd2 || best_score !== 5'd4)
            $display("FAIL basic_hold got %0d/%0d want 2/4", level_idx, best_score);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        int cyc;
        set_levels(16'h0000, 16'h8001, 16'h0000, 16'h0000);
        pulse_start(16'h000C);
        wait_done(cyc);
        total++;
        if (cyc != 5) $display("FAIL wrap_latency got %0d want 5", cyc);
        else pass_cnt++;
        total++;
        if (level_idx !== 2'd1 || best_score !== 5'd2)
            $display("FAIL wrap_result got %0d/%0d want 1/2", level_idx, best_score);
        else pass_cnt++;
        total++;
        if (level_idx0 !== 2'd0 || best_score0 !== 5'd0)
            $display("FAIL wrap_shift0 got %0d/%0d want 0/0", level_idx0, best_score0);
        else pass_cnt++;
    endtask

    task automatic test_tie_zero;
        int cyc;
        set_levels(16'h000F, 16'h0000, 16'h0000, 16'h000F);
        pulse_start(16'h0078);
        wait_done(cyc);
        total++;
        if (cyc != 5 || level_idx !== 2'd0 || best_score !== 5'd4)
            $display("FAIL tie_result got c%0d %0d/%0d want c5 0/4", cyc, level_idx, best_score);
        else pass_cnt++;
        total++;
        if (level_idx0 !== 2'd0 || best_score0 !== 5'd1)
            $display("FAIL tie_shift0 got %0d/%0d want 0/1", level_idx0, best_score0);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if (best_score !== 5'd4) $display("FAIL idle_hold got %0d want 4", best_score);
        else pass_cnt++;
        set_levels(16'h0, 16'h0, 16'h0, 16'h0);
        pulse_start(16'hFFFF);
        total++;
        if (best_score !== 5'd4) $display("FAIL no_clear_on_start got %0d want 4", best_score);
        else pass_cnt++;
        wait_done(cyc);
        total++;
        if (cyc != 5 || level_idx !== 2'd0 || best_score !== 5'd0)
            $display("FAIL zero_result got c%0d %0d/%0d want c5 0/0", cyc, level_idx, best_score);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start_full;
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = -1;
        set_levels(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        pulse_start(16'hFFFF);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            total++;
            if (busy !== (c <= 4))
                $display("FAIL ign_busy c%0d got %0b want %0b", c, busy, (c <= 4));
            else pass_cnt++;
            if (c == 5) begin
                total++;
                if (level_idx !== 2'd3 || best_score !== 5'd16)
                    $display("FAIL full_result got %0d/%0d want 3/16", level_idx, best_score);
                else pass_cnt++;
                total++;
                if (level_idx0 !== 2'd3 || best_score0 !== 5'd16)
                    $display("FAIL full_shift0 got %0d/%0d want 3/16", level_idx0, best_score0);
                else pass_cnt++;
            end
            start_decoding = (c == 2 || c == 5);
        end
        start_decoding = 1'b0;
        total++;
        if (ndone != 1 || dcyc != 5)
            $display("FAIL ign_done got %0d pulses at c%0d want 1 at c5", ndone, dcyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int ndone;
        int cyc;
        ndone = 0;
        set_levels(16'h0000, 16'h0030, 16'h00F0, 16'h0F00);
        pulse_start(16'h0780);
        @(negedge clk);
        @(posedge clk);
        #2;
        nrst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_ctrl got busy %0b done %0b want 0 0", busy, done);
        else pass_cnt++;
        total++;
        if (level_idx !== 2'd0 || best_score !== 5'd0)
            $display("FAIL midrst_out got %0d/%0d want 0/0", level_idx, best_score);
        else pass_cnt++;
        @(negedge clk);
        nrst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        total++;
        if (ndone != 0) $display("FAIL midrst_quiet got %0d active cycles want 0", ndone);
        else pass_cnt++;
        pulse_start(16'h0780);
        wait_done(cyc);
        total++;
        if (cyc != 5 || level_idx !== 2'd2 || best_score !== 5'd4)
            $display("FAIL midrst_rerun got c%0d %0d/%0d want c5 2/4", cyc, level_idx, best_score);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_tie_zero();
        test_ignored_start_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
